bp_be_regfile_arbiter: RTL and testbench
========================================

Name: bp_be_regfile_arbiter

Overview:
- Sequencer and arbiter for one integer register file (1 write port; 1 synchronous read port with 1-cycle latency), sitting between the BE issue/writeback paths and the regfile instance.
- After reset, zero-fills x1..x31 through the write port, then shares the ports:
  - write port: writeback vs. debug/config writes;
  - read port: issue reads vs. debug/config reads.
- Returns debug read data through a valid-only response.

Parameters:
- dword_width_p, 64, register data width
- reg_addr_width_p, 5, register address width
- num_regs_p, 32, architectural registers; must equal 2**reg_addr_width_p

Ports:
- clk_i  in  1  single clock; all state on posedge
- reset_n_i  in  1  synchronous, active-low reset
- init_done_o  out  1  high once zero-fill is complete
- wb_v_i  in  1  writeback write request
- wb_addr_i  in  reg_addr_width_p  writeback destination
- wb_data_i  in  dword_width_p  writeback data
- wb_ready_o  out  1  writeback accepted when wb_v_i & wb_ready_o
- iss_r_v_i  in  1  issue read request
- iss_r_addr_i  in  reg_addr_width_p  issue read address
- dbg_v_i  in  1  debug request valid
- dbg_w_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  reg_addr_width_p  debug address
- dbg_data_i  in  dword_width_p  debug write data
- dbg_ready_o  out  1  debug request accepted when dbg_v_i & dbg_ready_o
- dbg_data_v_o  out  1  one-cycle pulse: debug read data valid
- dbg_data_o  out  dword_width_p  debug read data, held until next response
- rf_w_v_o  out  1  regfile write enable
- rf_w_addr_o  out  reg_addr_width_p  regfile write address
- rf_w_data_o  out  dword_width_p  regfile write data
- rf_r_v_o  out  1  regfile read enable
- rf_r_addr_o  out  reg_addr_width_p  regfile read address
- rf_r_data_i  in  dword_width_p  regfile read data, valid 1 cycle after rf_r_v_o

Behaviour:

Reset
- While reset_n_i = 0: state INIT, counter = 1.
- All outputs 0: init_done_o, wb_ready_o, dbg_ready_o, dbg_data_v_o, dbg_data_o, rf_w_v_o, rf_r_v_o.
- Reset asserted in any state, including mid-INIT or DBG_RD, aborts immediately.
- Any pending debug response is dropped; no dbg_data_v_o is issued for it.

FSM states: INIT, READY, DBG_RD.

INIT
- Each cycle: rf_w_v_o = 1, rf_w_addr_o = counter, rf_w_data_o = 0, counter += 1.
- The first cycle after reset release writes x1; the 31st cycle writes x31.
- When counter wraps 31→0, go to READY; init_done_o = 1 from the next cycle. Fill latency is 31 cycles.
- In INIT: wb_ready_o = 0, dbg_ready_o = 0, rf_r_v_o = 0; iss_r_v_i is ignored.

READY: write port (wb has priority)
- wb_ready_o = 1.
- If wb_v_i: rf_w_* driven from wb_*.
- Else if dbg_v_i & dbg_w_i: rf_w_* driven from dbg_*, dbg_ready_o = 1.
- A debug write with wb_v_i high waits (dbg_ready_o = 0).

READY: read port (issue has priority)
- If iss_r_v_i: rf_r_v_o = 1, rf_r_addr_o = iss_r_addr_i.
- Else if dbg_v_i & ~dbg_w_i: rf_r_v_o = 1, rf_r_addr_o = dbg_addr_i, dbg_ready_o = 1, go to DBG_RD.

Register x0
- Any accepted write to address 0 gets its handshake, but rf_w_v_o = 0 (suppressed).
- Debug read of x0 returns rf_r_data_i unchanged; the regfile supplies 0.

DBG_RD (exactly 1 cycle)
- dbg_data_o <= rf_r_data_i, registered on this edge.
- dbg_data_v_o = 1 in the following cycle.
- dbg_ready_o = 0.
- Write arbitration proceeds as in READY.
- Issue reads are allowed; the debug address was already launched.
- Return to READY.
- Debug read turnaround: accept at cycle N, dbg_data_v_o at cycle N+2. Back-to-back debug reads are accepted no closer than every 2 cycles.

Simultaneous events
- wb and iss together in READY: both proceed; the ports are independent.
- dbg_v_i with dbg_w_i is evaluated only against the write port; a read only against the read port.
- Same-cycle write and read of the same address: the read returns the old value (no bypass in this block).

Assertions (verification)
- dbg_v_i held and stable until accepted.
- No rf_w_v_o to address 0.

Test Plan:
1. Release reset, idle inputs → rf_w_v_o = 1 for 31 cycles with addr 1..31 and data 0; init_done_o = 1 at cycle 31; wb_ready_o = 0 throughout INIT.
2. READY, wb_v_i = 1 addr 5 data 0xABCD, same cycle dbg write addr 6 → cycle 0: rf_w addr 5, dbg_ready_o = 0; cycle 1: rf_w addr 6 data dbg_data_i, dbg_ready_o = 1.
3. Debug read addr 7 (regfile holds 0x1234) with iss_r_v_i = 0 → accepted at N, rf_r_addr_o = 7; dbg_data_v_o = 1 and dbg_data_o = 0x1234 at N+2; dbg_ready_o = 0 at N+1.
4. Debug read with iss_r_v_i = 1 addr 3 for 3 cycles → rf_r_addr_o = 3 each cycle, dbg_ready_o = 0; debug read accepted the cycle iss_r_v_i drops.
5. wb_v_i addr 0 data 0xFF → wb_ready_o = 1, rf_w_v_o = 0.
6. Drop reset_n_i at INIT cycle 10 and during DBG_RD → all outputs 0; after release the fill restarts at x1; no dbg_data_v_o pulse.

Source files
------------

// File: rtl/bp_be_regfile_arbiter.sv
// Regfile sequencer/arbiter: zero-fills x1..x(N-1) after reset, then shares
// the single write and read ports between writeback/issue and debug traffic.
module bp_be_regfile_arbiter #(
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int num_regs_p       = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    output logic                        init_done_o,

    input  logic                        wb_v_i,
    input  logic [reg_addr_width_p-1:0] wb_addr_i,
    input  logic [dword_width_p-1:0]    wb_data_i,
    output logic                        wb_ready_o,

    input  logic                        iss_r_v_i,
    input  logic [reg_addr_width_p-1:0] iss_r_addr_i,

    input  logic                        dbg_v_i,
    input  logic                        dbg_w_i,
    input  logic [reg_addr_width_p-1:0] dbg_addr_i,
    input  logic [dword_width_p-1:0]    dbg_data_i,
    output logic                        dbg_ready_o,
    output logic                        dbg_data_v_o,
    output logic [dword_width_p-1:0]    dbg_data_o,

    output logic                        rf_w_v_o,
    output logic [reg_addr_width_p-1:0] rf_w_addr_o,
    output logic [dword_width_p-1:0]    rf_w_data_o,
    output logic                        rf_r_v_o,
    output logic [reg_addr_width_p-1:0] rf_r_addr_o,
    input  logic [dword_width_p-1:0]    rf_r_data_i
);

    typedef enum logic [1:0] {S_INIT, S_READY, S_DBG_RD} state_e;

    state_e                      state_r, state_n;
    logic [reg_addr_width_p-1:0] cnt_r;
    logic                        dbg_data_v_r;
    logic [dword_width_p-1:0]    dbg_data_r;

    logic                        w_v, r_v, wb_rdy, dbg_rdy, done, rd_idle;
    logic [reg_addr_width_p-1:0] w_addr, r_addr;
    logic [dword_width_p-1:0]    w_data;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= S_INIT;
            cnt_r        <= reg_addr_width_p'(1);
            dbg_data_v_r <= 1'b0;
            dbg_data_r   <= '0;
        end else begin
            state_r      <= state_n;
            dbg_data_v_r <= (state_r == S_DBG_RD);
            if (state_r == S_INIT)
                cnt_r <= cnt_r + 1'b1;
            if (state_r == S_DBG_RD)
                dbg_data_r <= rf_r_data_i;
        end
    end

    always_comb begin
        state_n = state_r;
        w_v     = 1'b0;
        w_addr  = wb_addr_i;
        w_data  = wb_data_i;
        r_v     = 1'b0;
        r_addr  = iss_r_addr_i;
        wb_rdy  = 1'b0;
        dbg_rdy = 1'b0;
        done    = 1'b0;
        rd_idle = 1'b0;
        case (state_r)
            S_INIT: begin
                w_v    = 1'b1;
                w_addr = cnt_r;
                w_data = '0;
                if (cnt_r == reg_addr_width_p'(num_regs_p - 1))
                    state_n = S_READY;
            end
            default: begin
                done    = 1'b1;
                wb_rdy  = 1'b1;
                state_n = S_READY;
                // While the debug read is in flight no new debug request of either kind is taken.
                rd_idle = (state_r == S_READY);
                if (wb_v_i) begin
                    w_v = (wb_addr_i != '0);
                end else if (dbg_v_i && dbg_w_i && rd_idle) begin
                    w_v     = (dbg_addr_i != '0);
                    w_addr  = dbg_addr_i;
                    w_data  = dbg_data_i;
                    dbg_rdy = 1'b1;
                end
                if (iss_r_v_i) begin
                    r_v = 1'b1;
                end else if (dbg_v_i && !dbg_w_i && rd_idle) begin
                    r_v     = 1'b1;
                    r_addr  = dbg_addr_i;
                    dbg_rdy = 1'b1;
                    state_n = S_DBG_RD;
                end
            end
        endcase
    end

    assign init_done_o  = reset_n_i & done;
    assign wb_ready_o   = reset_n_i & wb_rdy;
    assign dbg_ready_o  = reset_n_i & dbg_rdy;
    assign dbg_data_v_o = reset_n_i & dbg_data_v_r;
    assign dbg_data_o   = reset_n_i ? dbg_data_r : '0;
    assign rf_w_v_o     = reset_n_i & w_v;
    assign rf_w_addr_o  = w_addr;
    assign rf_w_data_o  = w_data;
    assign rf_r_v_o     = reset_n_i & r_v;
    assign rf_r_addr_o  = r_addr;

endmodule

// File: tb/tb_bp_be_regfile_arbiter.sv
// Bench for bp_be_regfile_arbiter: behavioural regfile plus a cycle-counting
// reference model of fill, arbitration and debug read turnaround.
module tb_bp_be_regfile_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          init_done;
  logic          wb_v, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          iss_v;
  logic [AW-1:0] iss_addr;
  logic          dbg_v, dbg_w, dbg_ready, dbg_data_v;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data, dbg_rdata;
  logic          rf_w_v, rf_r_v;
  logic [AW-1:0] rf_w_addr, rf_r_addr;
  logic [DW-1:0] rf_w_data, rf_r_data;

  always #5 clk = ~clk;

  bp_be_regfile_arbiter #(.dword_width_p(DW), .reg_addr_width_p(AW), .num_regs_p(NR)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .init_done_o(init_done),
    .wb_v_i(wb_v), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready),
    .iss_r_v_i(iss_v), .iss_r_addr_i(iss_addr),
    .dbg_v_i(dbg_v), .dbg_w_i(dbg_w), .dbg_addr_i(dbg_addr), .dbg_data_i(dbg_data),
    .dbg_ready_o(dbg_ready), .dbg_data_v_o(dbg_data_v), .dbg_data_o(dbg_rdata),
    .rf_w_v_o(rf_w_v), .rf_w_addr_o(rf_w_addr), .rf_w_data_o(rf_w_data),
    .rf_r_v_o(rf_r_v), .rf_r_addr_o(rf_r_addr), .rf_r_data_i(rf_r_data)
  );

  // Regfile driven by the DUT: synchronous read returns the pre-write value.
  logic [DW-1:0] mem [NR];
  always @(posedge clk) begin
    if (rf_r_v) rf_r_data <= mem[rf_r_addr];
    if (rf_w_v) mem[rf_w_addr] <= rf_w_data;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: registers contents, fill progress and time of last debug read accept.
  logic [DW-1:0] ref_mem [NR];
  int            cyc = 0, fill = 0, acc_cyc = -10;
  logic [DW-1:0] resp_m = '0, dbg_out_m = '0;
  logic          m_dbg_acc;

  task automatic step();
    logic e_done = 0, e_wbr = 0, e_dbgr = 0, e_wv = 0, e_rv = 0, e_dv = 0, acc_rd = 0, busy;
    logic [AW-1:0] e_wa = '0, e_ra = '0;
    logic [DW-1:0] e_wd = '0, e_do = '0;
    m_dbg_acc = 0;
    if (reset_n) begin
      e_dv = (cyc == acc_cyc + 2);
      e_do = dbg_out_m;
      if (fill < NR - 1) begin
        e_wv = 1; e_wa = AW'(fill + 1); e_wd = '0;
      end else begin
        e_done = 1; e_wbr = 1;
        busy = (cyc == acc_cyc + 1);
        if (wb_v) begin
          e_wv = (wb_addr != 0); e_wa = wb_addr; e_wd = wb_data;
        end else if (dbg_v && dbg_w && !busy) begin
          e_wv = (dbg_addr != 0); e_wa = dbg_addr; e_wd = dbg_data; e_dbgr = 1;
        end
        if (iss_v) begin
          e_rv = 1; e_ra = iss_addr;
        end else if (dbg_v && !dbg_w && !busy) begin
          e_rv = 1; e_ra = dbg_addr; e_dbgr = 1; acc_rd = 1;
        end
      end
    end
    m_dbg_acc = e_dbgr;
    @(negedge clk);
    chk("init_done", init_done, e_done);
    chk("wb_ready", wb_ready, e_wbr);
    chk("dbg_ready", dbg_ready, e_dbgr);
    chk("rf_w_v", rf_w_v, e_wv);
    chk("rf_r_v", rf_r_v, e_rv);
    chk("dbg_data_v", dbg_data_v, e_dv);
    chk("dbg_data", dbg_rdata, e_do);
    chk("x0_write", rf_w_v && rf_w_addr == 0, 0);
    if (e_wv) begin
      chk("rf_w_addr", rf_w_addr, e_wa);
      chk("rf_w_data", rf_w_data, e_wd);
    end
    if (e_rv) chk("rf_r_addr", rf_r_addr, e_ra);
    @(posedge clk);
    if (!reset_n) begin
      fill = 0; acc_cyc = -10; dbg_out_m = '0;
    end else begin
      if (cyc == acc_cyc + 1) dbg_out_m = resp_m;
      if (acc_rd) begin acc_cyc = cyc; resp_m = ref_mem[dbg_addr]; end
      if (fill < NR - 1) begin ref_mem[fill + 1] = '0; fill++; end
      else if (e_wv) ref_mem[e_wa] = e_wd;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    wb_v = 0; wb_addr = '0; wb_data = '0; iss_v = 0; iss_addr = '0;
    dbg_v = 0; dbg_w = 0; dbg_addr = '0; dbg_data = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_run(input int n);
    logic pend = 0;
    for (int i = 0; i < n; i++) begin
      wb_v = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom); wb_data = {$urandom, $urandom};
      iss_v = ($urandom_range(0, 2) == 0); iss_addr = AW'($urandom);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; dbg_w = 1'($urandom_range(0, 1)); dbg_addr = AW'($urandom);
        dbg_data = {$urandom, $urandom};
      end
      dbg_v = pend;
      step();
      if (m_dbg_acc) pend = 0;
    end
    idle();
  endtask

  task automatic dbg_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_v = 1; dbg_w = w; dbg_addr = a; dbg_data = d;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      mem[i] = (i == 0) ? '0 : {$urandom, $urandom};
      ref_mem[i] = (i == 0) ? '0 : {$urandom, $urandom};
    end
    rf_r_data = '0;
    idle();
    reset_n = 0;
    @(posedge clk); #1;
    run(3);
    reset_n = 1;
    run(NR + 1);

    // wb wins the write port; debug write lands next cycle
    wb_v = 1; wb_addr = 5; wb_data = 64'hABCD; dbg_req(1, 6, 64'h5555);
    step();
    wb_v = 0; step();
    idle();

    // debug read turnaround of a known value
    wb_v = 1; wb_addr = 7; wb_data = 64'h1234; step();
    wb_v = 0; dbg_req(0, 7, '0); step();
    idle(); run(3);

    // issue reads hold off a debug read
    iss_v = 1; iss_addr = 3; dbg_req(0, 5, '0); run(3);
    iss_v = 0; step();
    idle(); run(3);

    // x0 writes handshake but never reach the regfile; x0 debug read is zero
    wb_v = 1; wb_addr = 0; wb_data = 64'hFF; step();
    wb_v = 0; dbg_req(1, 0, 64'h77); step();
    dbg_req(0, 0, '0); step();
    idle(); run(3);

    rand_run(300);

    // reset in the middle of the fill
    reset_n = 0; run(2);
    reset_n = 1; run(10);
    reset_n = 0; run(2);
    reset_n = 1; run(NR + 1);

    // reset while a debug read is in flight
    dbg_req(0, 5, '0); step();
    idle(); reset_n = 0; step();
    reset_n = 1; run(NR + 3);

    rand_run(300);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
